// File: rtl/frac_pwm_ctrl.sv
// Host configuration scheduler for frac_pwm: shadow No/N/mf, validated commit, atomic apply at period boundary.
// Optional soft-start ramp of N is compiled in with `define FRAC_PWM_RAMP_EN.
module frac_pwm_ctrl #(
  parameter int          W         = 17,
  parameter int unsigned NO_RESET  = 4000
`ifdef FRAC_PWM_RAMP_EN
  , parameter int        RAMP_STEP = 16
`endif
) (
  input  logic         sys_clk,
  input  logic         sync_rst_n,
  input  logic         host_wr,
  input  logic [1:0]   host_addr,
  input  logic [W-1:0] host_wdata,
  input  logic [W-1:0] count,
  output logic [W-1:0] No,
  output logic [W-1:0] N,
  output logic [W-1:0] mf,
  output logic         host_busy,
  output logic         upd_done,
  output logic         upd_err
);

  localparam logic [W-1:0] NO_RST = NO_RESET[W-1:0];

  // Host port: host_wr is a one-cycle strobe with no ready; it is accepted only
  // while host_busy is low and silently dropped otherwise.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1
`ifdef FRAC_PWM_RAMP_EN
    , RAMP = 2'd2
`endif
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] count_q;
  logic [W-1:0] no_sh, n_sh, mf_sh;
  logic [W-1:0] no_sh_d, n_sh_d, mf_sh_d;
  logic [W-1:0] no_d, n_d, mf_d;
  logic         done_d, err_d;
  logic         bnd, wr_ok, commit_req, no_valid;
  logic [W-1:0] n_t_new;

  assign bnd        = (count == '0) && (count_q != '0);
  assign wr_ok      = host_wr && (state_q == IDLE);
  assign commit_req = wr_ok && (host_addr == 2'd3) && host_wdata[0];
  assign no_valid   = (no_sh >= W'(2));
  assign n_t_new    = (n_sh < no_sh) ? n_sh : no_sh;
  assign host_busy  = (state_q != IDLE);

`ifdef FRAC_PWM_RAMP_EN
  localparam logic [W:0] STEP = (W+1)'(RAMP_STEP);

  logic [W-1:0] n_t_q, n_t_d, ramp_tgt, n_step, dn_gap;
  logic [W:0]   up_sum;
  logic         step_done;

  // In PEND the target is being latched this edge, so step toward the fresh value.
  assign ramp_tgt = (state_q == PEND) ? n_t_new : n_t_q;
  assign up_sum   = {1'b0, N} + STEP;
  assign dn_gap   = N - ramp_tgt;

  always_comb begin
    n_step = ramp_tgt;
    if (N < ramp_tgt) begin
      n_step = (up_sum >= {1'b0, ramp_tgt}) ? ramp_tgt : up_sum[W-1:0];
    end else if (N > ramp_tgt) begin
      n_step = ({1'b0, dn_gap} <= STEP) ? ramp_tgt : (N - STEP[W-1:0]);
    end
  end

  assign step_done = (n_step == ramp_tgt);
`endif

  always_ff @(posedge sys_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) state_q <= IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (commit_req && no_valid) state_d = PEND;
`ifdef FRAC_PWM_RAMP_EN
      PEND: if (bnd) state_d = step_done ? IDLE : RAMP;
      RAMP: if (bnd && step_done) state_d = IDLE;
`else
      PEND: if (bnd) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    no_sh_d = no_sh;
    n_sh_d  = n_sh;
    mf_sh_d = mf_sh;
    no_d    = No;
    n_d     = N;
    mf_d    = mf;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef FRAC_PWM_RAMP_EN
    n_t_d   = n_t_q;
`endif
    case (state_q)
      IDLE: begin
        if (wr_ok) begin
          case (host_addr)
            2'd0:    no_sh_d = host_wdata;
            2'd1:    n_sh_d  = host_wdata;
            2'd2:    mf_sh_d = host_wdata;
            default: err_d   = host_wdata[0] && !no_valid;
          endcase
        end
      end
      PEND: begin
        if (bnd) begin
          no_d = no_sh;
          mf_d = mf_sh;
`ifdef FRAC_PWM_RAMP_EN
          n_t_d  = n_t_new;
          n_d    = n_step;
          done_d = step_done;
`else
          n_d    = n_t_new;
          done_d = 1'b1;
`endif
        end
      end
`ifdef FRAC_PWM_RAMP_EN
      RAMP: begin
        if (bnd) begin
          n_d    = n_step;
          done_d = step_done;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      count_q  <= '0;
      no_sh    <= NO_RST;
      n_sh     <= '0;
      mf_sh    <= '0;
      No       <= NO_RST;
      N        <= '0;
      mf       <= '0;
      upd_done <= 1'b0;
      upd_err  <= 1'b0;
`ifdef FRAC_PWM_RAMP_EN
      n_t_q    <= '0;
`endif
    end else begin
      count_q  <= count;
      no_sh    <= no_sh_d;
      n_sh     <= n_sh_d;
      mf_sh    <= mf_sh_d;
      No       <= no_d;
      N        <= n_d;
      mf       <= mf_d;
      upd_done <= done_d;
      upd_err  <= err_d;
`ifdef FRAC_PWM_RAMP_EN
      n_t_q    <= n_t_d;
`endif
    end
  end

endmodule

// File: tb/tb_frac_pwm_ctrl.sv
// Directed self-checking bench for frac_pwm_ctrl; covers both the plain and FRAC_PWM_RAMP_EN builds.
module tb_frac_pwm_ctrl;
  localparam int W = 17;
`ifdef FRAC_PWM_RAMP_EN
  localparam int STEP = 16;
`endif

  logic         sys_clk = 1'b0;
  logic         sync_rst_n;
  logic         host_wr;
  logic [1:0]   host_addr;
  logic [W-1:0] host_wdata;
  logic [W-1:0] count;
  logic [W-1:0] No, N, mf;
  logic         host_busy, upd_done, upd_err;

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int err_cnt  = 0;
  logic [W-1:0] exp_q[$];

  frac_pwm_ctrl dut (
    .sys_clk    (sys_clk),
    .sync_rst_n (sync_rst_n),
    .host_wr    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .count      (count),
    .No         (No),
    .N          (N),
    .mf         (mf),
    .host_busy  (host_busy),
    .upd_done   (upd_done),
    .upd_err    (upd_err)
  );

  // ---------------- clock / reset ----------------
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (upd_done) done_cnt++;
    if (upd_err)  err_cnt++;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic host_write(input logic [1:0] addr, input int data);
    host_wr    = 1'b1;
    host_addr  = addr;
    host_wdata = W'(data);
    tick();
    host_wr    = 1'b0;
  endtask

  task automatic count_run(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      count = W'(i);
      tick();
    end
  endtask

  task automatic bnd_edge();
    count = '0;
    tick();
  endtask

  task automatic apply_reset();
    sync_rst_n = 1'b0;
    tick();
    sync_rst_n = 1'b1;
    tick();
  endtask

  // Expected sequence of N values, one per boundary, for a move from n_old to tgt.
  task automatic push_model(input int n_old, input int tgt);
`ifdef FRAC_PWM_RAMP_EN
    int n;
    n = n_old;
    do begin
      if (n < tgt)      n = (tgt - n > STEP) ? n + STEP : tgt;
      else if (n > tgt) n = (n - tgt > STEP) ? n - STEP : tgt;
      exp_q.push_back(W'(n));
    end while (n != tgt);
`else
    exp_q.push_back(W'(tgt));
`endif
  endtask

  // Called with count at the last value of a period; consumes exp_q one boundary at a time.
  task automatic settle(input int p);
    logic [W-1:0] e;
    while (exp_q.size() > 0) begin
      bnd_edge();
      e = exp_q.pop_front();
      check("n_at_bnd", N, e);
      check("done_at_bnd", upd_done, exp_q.size() == 0);
      check("busy_at_bnd", host_busy, exp_q.size() != 0);
      if (exp_q.size() > 0) count_run(1, p - 1);
    end
  endtask

  // ---------------- stimulus ----------------
  int done_saved;

  initial begin
    sync_rst_n = 1'b0;
    host_wr    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    count      = '0;
    repeat (3) tick();
    sync_rst_n = 1'b1;
    tick();

    // Reset state and idle periods
    check("rst_no", No, 4000);
    check("rst_n", N, 0);
    check("rst_mf", mf, 0);
    check("rst_busy", host_busy, 0);
    check("rst_done", upd_done, 0);
    check("rst_err", upd_err, 0);
    repeat (3) begin
      count_run(1, 19);
      bnd_edge();
    end
    check("idle_no", No, 4000);
    check("idle_n", N, 0);
    check("idle_pulses", done_cnt + err_cnt, 0);

    // Commit mid-period; outputs held until boundary
    host_write(2'd0, 400);
    host_write(2'd1, 200);
    host_write(2'd2, 1);
    check("shadow_no_effect", No, 4000);
    count_run(1, 150);
    host_write(2'd3, 1);
    check("commit_busy", host_busy, 1);
    count_run(151, 399);
    check("pend_no", No, 4000);
    check("pend_n", N, 0);
    check("pend_mf", mf, 0);
    check("pend_done_cnt", done_cnt, 0);
    push_model(0, 200);
    settle(400);
    check("apply_no", No, 400);
    check("apply_mf", mf, 1);
    tick();
    check("done_fall", upd_done, 0);
    check("done_cnt_1", done_cnt, 1);

    // Invalid commit (No < 2) and ignored commit (bit0 = 0)
    host_write(2'd0, 1);
    host_write(2'd3, 1);
    check("err_pulse", upd_err, 1);
    check("err_busy", host_busy, 0);
    tick();
    check("err_fall", upd_err, 0);
    check("err_cnt_1", err_cnt, 1);
    count_run(1, 9);
    bnd_edge();
    check("err_no_kept", No, 400);
    check("err_n_kept", N, 200);
    check("err_busy_bnd", host_busy, 0);
    check("err_no_done", done_cnt, 1);
    host_write(2'd0, 400);
    host_write(2'd3, 0);
    check("bit0_ignored", host_busy, 0);

    // N clamped to No; writes while busy dropped
    host_write(2'd1, 500);
    host_write(2'd3, 1);
    check("clamp_busy", host_busy, 1);
    host_write(2'd1, 7);
    host_write(2'd2, 9);
    host_write(2'd3, 1);
    push_model(200, 400);
    count_run(1, 399);
    settle(400);
    check("clamp_n", N, 400);
    check("clamp_mf", mf, 1);
    tick();
    check("clamp_done_fall", upd_done, 0);
    host_write(2'd0, 300);
    host_write(2'd3, 1);
    push_model(400, 300);
    count_run(1, 399);
    settle(400);
    check("busy_wr_n_dropped", N, 300);
    check("busy_wr_mf_dropped", mf, 1);
    check("new_no", No, 300);
    tick();
    check("done_cnt_3", done_cnt, 3);

`ifdef FRAC_PWM_RAMP_EN
    // Ramp sequences from the hand-worked example
    apply_reset();
    check("rst2_n", N, 0);
    host_write(2'd0, 400);
    host_write(2'd1, 40);
    host_write(2'd3, 1);
    exp_q.push_back(W'(16));
    exp_q.push_back(W'(32));
    exp_q.push_back(W'(40));
    count_run(1, 399);
    settle(400);
    tick();
    host_write(2'd1, 0);
    host_write(2'd3, 1);
    exp_q.push_back(W'(24));
    exp_q.push_back(W'(8));
    exp_q.push_back(W'(0));
    count_run(1, 399);
    settle(400);
    tick();
    check("done_cnt_5", done_cnt, 5);
`endif

    // Asynchronous reset while busy
    host_write(2'd1, 200);
    host_write(2'd3, 1);
    check("rst_mid_busy", host_busy, 1);
`ifdef FRAC_PWM_RAMP_EN
    count_run(1, 399);
    bnd_edge();
    check("ramp_first_step", N, 16);
    check("ramp_busy", host_busy, 1);
`endif
    count_run(1, 50);
    done_saved = done_cnt;
    #2;
    sync_rst_n = 1'b0;
    #1;
    check("async_no", No, 4000);
    check("async_n", N, 0);
    check("async_mf", mf, 0);
    check("async_busy", host_busy, 0);
    tick();
    sync_rst_n = 1'b1;
    repeat (2) begin
      count_run(1, 399);
      bnd_edge();
    end
    check("post_rst_no_done", done_cnt, done_saved);
    check("post_rst_n", N, 0);
    check("post_rst_busy", host_busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frac_pwm_ctrl.md
# frac_pwm_ctrl

Host-side configuration scheduler for `frac_pwm`. It holds shadow copies of the period divider `No`, integer duty `N` and fractional duty `mf`, and validates a host commit. It applies the new values atomically at the next PWM period boundary, so a period never mixes old and new settings. An optional soft-start ramp moves `N` toward its target in fixed steps, one step per period.

## Interface
- `W`, 17, width of `No`/`N`/`mf`/`count`/`host_wdata`
- `NO_RESET`, 4000, reset value of `No` and its shadow
- `RAMP_STEP`, 16, `N` increment/decrement per period; ramp build only; must be ≥1
- `sys_clk`  in  1  system clock, rising edge
- `sync_rst_n`  in  1  reset, asynchronous assert, active-low
- `host_wr`  in  1  write strobe, one-cycle, sampled on the rising edge
- `host_addr`  in  2  0=`No` shadow, 1=`N` shadow, 2=`mf` shadow, 3=commit
- `host_wdata`  in  W  write data; for commit, bit0=1 requests commit
- `count`  in  W  instantaneous count from `frac_pwm`
- `No`  out  W  period divider to `frac_pwm`
- `N`  out  W  integer duty to `frac_pwm`
- `mf`  out  W  fractional duty to `frac_pwm`
- `host_busy`  out  1  commit pending or ramp in progress
- `upd_done`  out  1  one-cycle pulse when the commit is fully applied
- `upd_err`  out  1  one-cycle pulse when a commit is rejected

## Operation
- Reset values: `No`=`NO_RESET`, `N`=0, `mf`=0, the three shadows the same, `host_busy`=0, `upd_done`=0, `upd_err`=0, state IDLE, `count_q`=0.
- Boundary: `bnd` = (`count`==0) && (`count_q`!=0), where `count_q` is `count` registered every cycle.
- States:
  - IDLE
    - Writes to addr 0–2 load the addressed shadow.
    - Commit with bit0=1 and shadow `No` ≥ 2 goes to PEND.
    - Commit with shadow `No` < 2 pulses `upd_err` and stays in IDLE; shadows are kept.
    - Commit with bit0=0 is ignored.
  - PEND
    - On `bnd`, load `No` and `mf` from the shadows.
    - Target `N_t` = min(shadow `N`, shadow `No`), latched at this same edge.
    - Without ramp: load `N`=`N_t`, pulse `upd_done`, return to IDLE.
    - With ramp: apply the first step and go to RAMP. If that step reaches `N_t`, pulse `upd_done` and return to IDLE instead.
  - RAMP (ramp build only)
    - On each `bnd`, `N` moves toward `N_t` by `RAMP_STEP`, clamped so it never overshoots `N_t`; up and down are symmetric.
    - The edge at which `N`==`N_t` pulses `upd_done` and returns to IDLE.
- `host_busy` = 1 in PEND and RAMP.
- All `host_wr` while busy are ignored, including commits and shadow writes; no error is signalled.
- Arithmetic is unsigned W-bit.
  - Ramp-up: `N`+`RAMP_STEP` is computed at W+1 bits before comparing against `N_t`, so it cannot wrap.
  - Ramp-down compares before subtracting, so it cannot underflow.
- `host_wr` coincident with `bnd` in IDLE is a normal write; the boundary has no effect in IDLE.

## Timing
- All outputs are registered; no combinational path from input to output.
- Shadow write: the shadow updates at the sampling edge. It has no effect on `No`/`N`/`mf` until a commit.
- Commit request to PEND: one edge; `host_busy` is high the following cycle.
- Apply: outputs change at the edge where `bnd` is sampled true, and are visible the cycle after it.
- `upd_done`/`upd_err`: high for exactly one cycle. `upd_done` coincides with the final `N` value appearing; `host_busy` falls in the same cycle.
- Latency, commit to done: ≤ one PWM period without ramp. With ramp it is ceil(|`N_t`−`N`_old| / `RAMP_STEP`) boundaries, minimum 1.
- Reset mid-operation: all registers return to reset values asynchronously. A pending commit is discarded and a ramp is abandoned, with no `upd_done`.
- If `count` never returns to 0, PEND/RAMP holds indefinitely; the host recovers via reset.

## Configuration
- `FRAC_PWM_RAMP_EN` defined:
  - The RAMP state and `RAMP_STEP` stepping are compiled in.
- Undefined:
  - No RAMP state; `N` jumps to `N_t` at the commit boundary.
  - `RAMP_STEP` is unused.
  - Port list is unchanged.

## Test plan
- Reset, no writes → `No`=4000, `N`=0, `mf`=0, `host_busy`=0, no pulses over 3 periods.
- Ramp off; write `No`=400, `N`=200, `mf`=1, commit mid-period → outputs unchanged until the first `count` 399→0. Then all three update together, `upd_done` pulses once and `host_busy` falls.
- Commit with shadow `No`=1 → `upd_err` one-cycle pulse, state stays IDLE, outputs unchanged, `host_busy` never rises.
- Ramp on, `RAMP_STEP`=16; from `N`=0 commit `N`=40, `No`=400 → `N` is 16, 32, 40 on three successive boundaries, `upd_done` at the third. Then commit `N`=0 → 24, 8, 0.
- Write `N`=500 with `No`=400, commit → `N` settles at 400. A write to addr 1 while `host_busy`=1 is ignored (shadow unchanged).
- Assert `sync_rst_n`=0 during RAMP → outputs go to reset values immediately without waiting for a clock edge, and no `upd_done` is produced after release.
